// File: rtl/nn_dense_engine.sv
// Two-layer fully connected inference engine: a 272-entry signed weight bank,
// one MAC per cycle, ReLU on the hidden layer, saturated signed outputs.
module nn_dense_engine #(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned WIDTH_W    = 9,
  parameter  int unsigned LENGHT_I   = 32,
  parameter  int unsigned LENGHT_MID = 8,
  parameter  int unsigned LENGHT_O   = 2,
  parameter  int unsigned SHIFT      = 0,
  localparam int unsigned N_W        = LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O,
  localparam int unsigned ACC_W      = WIDTH + WIDTH_W + $clog2(LENGHT_I) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [N_W*WIDTH_W-1:0]       w_i,
  input  logic                         start,
  input  logic [LENGHT_I*WIDTH-1:0]    x_i,
  output logic                         w_valid,
  output logic                         busy,
  output logic                         done,
  output logic [LENGHT_O*WIDTH-1:0]    y_o
);

  localparam int unsigned PW      = WIDTH + WIDTH_W;
  localparam int unsigned KW      = $clog2(LENGHT_I);
  localparam int unsigned NW      = $clog2(LENGHT_MID);
  localparam int unsigned OW      = (LENGHT_O > 1) ? $clog2(LENGHT_O) : 1;
  localparam int unsigned WBW     = $clog2(N_W*WIDTH_W);
  localparam int unsigned XBW     = $clog2(LENGHT_I*WIDTH);
  localparam int unsigned L2_BASE = LENGHT_I*LENGHT_MID;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_L1_MAC, S_L1_ACT, S_L2_MAC, S_L2_ACT, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic                       w_valid_q, w_valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [N_W*WIDTH_W-1:0]     w_q, w_d;
  logic [LENGHT_I*WIDTH-1:0]  x_q, x_d;
  logic signed [WIDTH-1:0]    h_q [LENGHT_MID];
  logic signed [WIDTH-1:0]    h_d [LENGHT_MID];
  logic signed [WIDTH-1:0]    y_next_q [LENGHT_O];
  logic signed [WIDTH-1:0]    y_next_d [LENGHT_O];
  logic [LENGHT_O*WIDTH-1:0]  y_q, y_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [KW-1:0]              k_q, k_d;
  logic [NW-1:0]              n_q, n_d;

  logic                       l2_c;
  logic [WBW-1:0]             w_sel_c;
  logic [XBW-1:0]             x_sel_c;
  logic signed [WIDTH-1:0]    a_c;
  logic signed [WIDTH_W-1:0]  b_c;
  logic signed [PW-1:0]       prod_c;
  logic signed [ACC_W-1:0]    mac_c;
  logic signed [ACC_W-1:0]    shr_c;
  logic signed [WIDTH-1:0]    sat_c;

  // Shared MAC operand select, accumulate, and shift/saturate of the accumulator
  always_comb begin
    l2_c = (state_q == S_L2_MAC);
    if (l2_c) begin
      w_sel_c = WBW'((L2_BASE + 32'(n_q)*LENGHT_MID + 32'(k_q)) * WIDTH_W);
    end else begin
      w_sel_c = WBW'((32'(n_q)*LENGHT_I + 32'(k_q)) * WIDTH_W);
    end
    x_sel_c = XBW'(32'(k_q) * WIDTH);
    a_c     = l2_c ? h_q[k_q[NW-1:0]] : $signed(x_q[x_sel_c +: WIDTH]);
    b_c     = $signed(w_q[w_sel_c +: WIDTH_W]);
    prod_c  = $signed({{(PW-WIDTH){a_c[WIDTH-1]}}, a_c}) *
              $signed({{(PW-WIDTH_W){b_c[WIDTH_W-1]}}, b_c});
    mac_c   = acc_q + $signed({{(ACC_W-PW){prod_c[PW-1]}}, prod_c});
    shr_c   = acc_q >>> SHIFT;
    if (shr_c > SAT_MAX) begin
      sat_c = WIDTH'(SAT_MAX);
    end else if (shr_c < SAT_MIN) begin
      sat_c = WIDTH'(SAT_MIN);
    end else begin
      sat_c = WIDTH'(shr_c);
    end
  end

  always_comb begin
    state_d   = state_q;
    w_valid_d = w_valid_q;
    w_d       = w_q;
    x_d       = x_q;
    h_d       = h_q;
    y_next_d  = y_next_q;
    y_d       = y_q;
    acc_d     = acc_q;
    k_d       = k_q;
    n_d       = n_q;

    case (state_q)
      S_IDLE: begin
        // A load in the same cycle as start wins; start is dropped
        if (wr) begin
          w_d       = w_i;
          w_valid_d = 1'b1;
        end else if (start && w_valid_q) begin
          x_d     = x_i;
          acc_d   = '0;
          k_d     = '0;
          n_d     = '0;
          state_d = S_L1_MAC;
        end
      end
      S_L1_MAC: begin
        acc_d = mac_c;
        if (k_q == KW'(LENGHT_I-1)) state_d = S_L1_ACT;
        else                        k_d     = k_q + KW'(1);
      end
      S_L1_ACT: begin
        h_d[n_q] = sat_c[WIDTH-1] ? '0 : sat_c;
        acc_d    = '0;
        k_d      = '0;
        if (n_q == NW'(LENGHT_MID-1)) begin
          n_d     = '0;
          state_d = S_L2_MAC;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_L1_MAC;
        end
      end
      S_L2_MAC: begin
        acc_d = mac_c;
        if (k_q == KW'(LENGHT_MID-1)) state_d = S_L2_ACT;
        else                          k_d     = k_q + KW'(1);
      end
      S_L2_ACT: begin
        y_next_d[n_q[OW-1:0]] = sat_c;
        acc_d = '0;
        k_d   = '0;
        if (n_q == NW'(LENGHT_O-1)) begin
          n_d     = '0;
          state_d = S_DONE;
          for (int i = 0; i < int'(LENGHT_O); i++) y_d[i*WIDTH +: WIDTH] = y_next_d[i];
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_L2_MAC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      n_q       <= '0;
      for (int i = 0; i < int'(LENGHT_MID); i++) h_q[i] <= '0;
      for (int i = 0; i < int'(LENGHT_O); i++) y_next_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_q       <= w_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      n_q       <= n_d;
      h_q       <= h_d;
      y_next_q  <= y_next_d;
    end
  end

  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign y_o     = y_q;

endmodule

// File: tb/tb_nn_dense_engine.sv
// Bench for nn_dense_engine: directed and random networks checked against a
// plain-arithmetic model of the two-layer dense network.
module tb_nn_dense_engine;

  localparam int WIDTH   = 32;
  localparam int WIDTH_W = 9;
  localparam int LI      = 32;
  localparam int LM      = 8;
  localparam int LO      = 2;
  localparam int SHIFT   = 0;
  localparam int N_W     = LI*LM + LM*LO;
  localparam int LAT     = LM*(LI+1) + LO*(LM+1) + 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    wr;
  logic                    start;
  logic [N_W*WIDTH_W-1:0]  w_i;
  logic [LI*WIDTH-1:0]     x_i;
  logic                    w_valid;
  logic                    busy;
  logic                    done;
  logic [LO*WIDTH-1:0]     y_o;

  nn_dense_engine #(.SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_i(w_i), .start(start), .x_i(x_i),
    .w_valid(w_valid), .busy(busy), .done(done), .y_o(y_o)
  );

  always #5 clk = ~clk;

  int     wdrv  [N_W];
  int     wbank [N_W];
  int     xm    [LI];
  longint ey    [LO];
  int     chk_cnt  = 0;
  int     pass_cnt = 0;
  int     fail_cnt = 0;
  int     cyc, busy_cnt, done_cyc;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint satf(input longint a);
    if (a > SMAX) return SMAX;
    if (a < SMIN) return SMIN;
    return a;
  endfunction

  // Reference network evaluated on the bank the bench believes is loaded
  function automatic void model();
    longint h [LM];
    longint acc;
    for (int j = 0; j < LM; j++) begin
      acc = 0;
      for (int i = 0; i < LI; i++) acc += longint'(xm[i]) * longint'(wbank[j*LI+i]);
      h[j] = satf(acc >>> SHIFT);
      if (h[j] < 0) h[j] = 0;
    end
    for (int k = 0; k < LO; k++) begin
      acc = 0;
      for (int j = 0; j < LM; j++) acc += h[j] * longint'(wbank[LI*LM + k*LM + j]);
      ey[k] = satf(acc >>> SHIFT);
    end
  endfunction

  function automatic logic signed [63:0] yslice(input int k);
    logic [WIDTH-1:0] s;
    s = y_o[k*WIDTH +: WIDTH];
    return 64'($signed(s));
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1 && done_cyc == 0) done_cyc = cyc;
  endtask

  task automatic drive_w();
    for (int i = 0; i < N_W; i++) w_i[i*WIDTH_W +: WIDTH_W] = 9'(wdrv[i]);
  endtask

  task automatic drive_x();
    for (int i = 0; i < LI; i++) x_i[i*WIDTH +: WIDTH] = xm[i];
  endtask

  task automatic load();
    drive_w();
    wr = 1'b1;
    step();
    wr = 1'b0;
    wbank = wdrv;
  endtask

  task automatic kick();
    drive_x();
    model();
    cyc = 0; busy_cnt = 0; done_cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs to the done cycle and checks latency, busy span and results there
  task automatic finish(input string tag);
    while (done_cyc == 0 && cyc < LAT + 40) step();
    chk({tag, " latency"}, 64'(done_cyc), 64'(LAT));
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    for (int k = 0; k < LO; k++) chk($sformatf("%s y%0d", tag, k), yslice(k), ey[k]);
  endtask

  task automatic post_idle(input string tag);
    step();
    chk({tag, " done_low"}, 64'(done), 64'(0));
    chk({tag, " busy_low"}, 64'(busy), 64'(0));
  endtask

  task automatic idle_watch(input int n, input string tag);
    cyc = 0; busy_cnt = 0; done_cyc = 0;
    repeat (n) step();
    chk({tag, " no_busy"}, 64'(busy_cnt), 64'(0));
    chk({tag, " no_done"}, 64'(done_cyc), 64'(0));
  endtask

  task automatic rand_w();
    for (int i = 0; i < N_W; i++) wdrv[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic rand_x();
    for (int i = 0; i < LI; i++) xm[i] = int'($urandom());
  endtask

  initial begin
    reset = 1'b0; wr = 1'b0; start = 1'b0; w_i = '0; x_i = '0;
    cyc = 0; busy_cnt = 0; done_cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst w_valid", 64'(w_valid), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst y0", yslice(0), 64'(0));
    chk("rst y1", yslice(1), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Start with no weights loaded is dropped
    foreach (xm[i]) xm[i] = 5;
    drive_x();
    start = 1'b1; step(); start = 1'b0;
    idle_watch(300, "t4 nowts");
    chk("t4 w_valid", 64'(w_valid), 64'(0));
    chk("t4 y0", yslice(0), 64'(0));

    foreach (wdrv[i]) wdrv[i] = 1;
    load();
    chk("t1 w_valid", 64'(w_valid), 64'(1));
    foreach (xm[i]) xm[i] = 1;
    kick();
    chk("t1 busy_after_start", 64'(busy), 64'(1));
    finish("t1");
    chk("t1 y0 const", yslice(0), 64'(256));
    chk("t1 y1 const", yslice(1), 64'(256));
    post_idle("t1");

    foreach (wdrv[i]) wdrv[i] = 0;
    wdrv[5] = 1; wdrv[256] = 2;
    load();
    foreach (xm[i]) xm[i] = 0;
    xm[5] = 3;
    kick(); finish("t2");
    chk("t2 y0 const", yslice(0), 64'(6));
    chk("t2 y1 const", yslice(1), 64'(0));
    post_idle("t2");

    for (int i = 0; i < N_W; i++) wdrv[i] = (i < LI*LM) ? -1 : 1;
    load();
    foreach (xm[i]) xm[i] = 1;
    kick(); finish("t3 relu");
    chk("t3 relu y0 const", yslice(0), 64'(0));
    post_idle("t3 relu");

    for (int i = 0; i < N_W; i++) wdrv[i] = (i < LI*LM) ? 255 : 0;
    wdrv[LI*LM] = 1;
    load();
    foreach (xm[i]) xm[i] = 32'h7FFF_FFFF;
    kick(); finish("t3 sat_hi");
    chk("t3 sat_hi y0 const", yslice(0), SMAX);
    post_idle("t3 sat_hi");

    for (int i = LI*LM; i < N_W; i++) wdrv[i] = -256;
    load();
    kick(); finish("t3 sat_lo");
    chk("t3 sat_lo y0 const", yslice(0), SMIN);
    chk("t3 sat_lo y1 const", yslice(1), SMIN);
    post_idle("t3 sat_lo");

    for (int r = 0; r < 4; r++) begin
      rand_w(); load();
      rand_x(); kick();
      finish($sformatf("rand%0d", r));
      post_idle($sformatf("rand%0d", r));
    end

    // Load and input changes mid-run must not disturb the captured operands
    rand_w(); load();
    rand_x(); kick();
    while (cyc < 50) step();
    rand_w(); drive_w();
    rand_x(); drive_x();
    wr = 1'b1; step(); wr = 1'b0;
    finish("t5 midwr");
    rand_x(); drive_x();
    start = 1'b1; step(); start = 1'b0;
    chk("t5 start_in_done busy", 64'(busy), 64'(0));
    chk("t5 start_in_done done", 64'(done), 64'(0));
    kick();
    finish("t5 restart");
    post_idle("t5 restart");

    // Reset mid-run aborts everything at once
    rand_x(); kick();
    while (cyc < 100) step();
    reset = 1'b0;
    #1;
    chk("t6 busy", 64'(busy), 64'(0));
    chk("t6 w_valid", 64'(w_valid), 64'(0));
    chk("t6 done", 64'(done), 64'(0));
    chk("t6 y0", yslice(0), 64'(0));
    chk("t6 y1", yslice(1), 64'(0));
    cyc = 0; busy_cnt = 0; done_cyc = 0;
    repeat (3) step();
    reset = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    repeat (300) step();
    chk("t6 no_busy", 64'(busy_cnt), 64'(0));
    chk("t6 no_done", 64'(done_cyc), 64'(0));
    chk("t6 y0_after", yslice(0), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/nn_dense_engine.md
Name: nn_dense_engine

Overview:
- Compute stage directly downstream of the CPU-facing weight/input manager.
- Holds the 272 packed 9-bit weights delivered on the manager's wr/w_o strobe.
- On start, runs a two-layer fully connected network (LENGHT_I -> LENGHT_MID -> LENGHT_O) sequentially, one MAC per cycle, and returns a done pulse plus LENGHT_O results to the manager.

Parameters:
WIDTH, 32, signed input/activation/result width
WIDTH_W, 9, signed weight width
LENGHT_I, 32, input neurons
LENGHT_MID, 8, hidden neurons
LENGHT_O, 2, output neurons
N_W, LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O, weight count (272)
SHIFT, 0, arithmetic right shift applied to each accumulator before activation
ACC_W, WIDTH+WIDTH_W+$clog2(LENGHT_I)+1, accumulator width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wr  in  1  weight load strobe, 1-cycle pulse from manager
w_i  in  N_W x WIDTH_W  packed weights, index 0 = LSB slice
start  in  1  begin inference, 1-cycle pulse
x_i  in  LENGHT_I x WIDTH  packed input vector, index 0 = LSB slice
w_valid  out  1  weight bank has been loaded since reset
busy  out  1  inference in progress
done  out  1  1-cycle pulse, y_o valid
y_o  out  LENGHT_O x WIDTH  signed results

Behaviour:
- Reset (reset=0, async): state=IDLE; w_valid, busy, done = 0; y_o, weight bank, x latch, hidden regs, acc, counters = 0. Reset mid-inference aborts immediately; no done is produced.
- Weight layout:
  - Hidden weight for neuron j, input i = w[j*LENGHT_I+i].
  - Output weight for output k, hidden j = w[LENGHT_I*LENGHT_MID + k*LENGHT_MID + j].
  - All values signed two's complement.
- Weight load: wr=1 in IDLE copies w_i into the bank at that edge and sets w_valid=1. wr in any other state is ignored; the bank is unchanged.
- Start acceptance: start=1 in IDLE with w_valid=1 latches x_i and enters L1_MAC. Start is ignored if w_valid=0 or state != IDLE. If wr and start are both high in IDLE, the load happens and start is ignored.
- FSM:
  - IDLE -> L1_MAC on an accepted start.
  - L1_MAC: acc += x[k]*w_hidden[n][k] each cycle, k = 0..LENGHT_I-1. After k=LENGHT_I-1, go to L1_ACT.
  - L1_ACT (1 cycle): h[n] = relu(sat(acc>>>SHIFT)); acc=0; k=0. If n=LENGHT_MID-1, set n=0 and go to L2_MAC; else n++ and go to L1_MAC.
  - L2_MAC: acc += h[j]*w_out[n][j], j = 0..LENGHT_MID-1, then go to L2_ACT.
  - L2_ACT: y_next[n] = sat(acc>>>SHIFT), no ReLU. If n=LENGHT_O-1, go to DONE; else n++ and go to L2_MAC.
  - DONE (1 cycle): done=1, then IDLE.
- Arithmetic:
  - Products are full signed width and sign-extended into the ACC_W accumulator; no overflow is possible at defaults.
  - Shift is arithmetic (floor).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - relu maps negatives to 0.
- Output update: y_o updates all slices together at the edge entering DONE and holds until the next DONE or reset. Intermediate results are kept in internal regs and are never visible on y_o.
- busy: 1 from the cycle after an accepted start through the DONE cycle inclusive; 0 in IDLE.
- Latency: done is high exactly LENGHT_MID*(LENGHT_I+1) + LENGHT_O*(LENGHT_MID+1) + 1 cycles after the start edge (283 at defaults). A new start is accepted no earlier than the cycle after DONE.
- x_i and w_i may change freely after their capture edge without affecting the result.

Test Plan:
1. Load all weights=1, x all=1, SHIFT=0, start -> h=32 each, y_o={256,256}; done pulses exactly 283 cycles after start; busy high for 283 cycles.
2. Index ordering: all weights 0 except w[5]=1 and w[256]=2; x[5]=3, others 0 -> y_o[0]=6, y_o[1]=0.
3. ReLU/saturation:
   - Hidden weights -1, x=1 -> h=0, y_o={0,0}.
   - Hidden weights 255, x=32'h7FFFFFFF -> h saturates to 32'h7FFFFFFF.
   - Then output weights -256 -> y_o={32'h80000000,32'h80000000}.
4. start before any wr -> ignored: busy=0, done never pulses, y_o=0. Then wr followed by start runs normally.
5. wr with different weights at cycle 50 of a run -> ignored; result matches the original weights. A start pulse in the DONE cycle is ignored; start on the next cycle is accepted.
6. Assert reset=0 at cycle 100 of a run -> busy=0, y_o=0, w_valid=0 immediately; no done pulse. After release, start without wr is ignored.
